// File: rtl/gecko_pkg.sv
// Shared gecko pipeline types, RV32I load/store funct3 encodings and the
// load align/extend helper used by the memory-return stage.
package gecko_pkg;

  localparam logic [2:0] RV32I_FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] RV32I_FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] RV32I_FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] RV32I_FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] RV32I_FUNCT3_LS_HU = 3'b101;

  typedef struct packed {
    logic [4:0] addr;
    logic [2:0] op;
    logic [1:0] offset;
    logic [2:0] reg_status;
    logic       jump_flag;
  } gecko_mem_operation_t;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic        speculative;
    logic [2:0]  reg_status;
    logic        jump_flag;
  } gecko_operation_t;

  function automatic logic [31:0] gecko_get_load_result(
    input logic [31:0] data,
    input logic [1:0]  offset,
    input logic [2:0]  op
  );
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    lane_b = data[{offset, 3'b000} +: 8];
    lane_h = data[{offset[1], 4'b0000} +: 16];
    case (op)
      RV32I_FUNCT3_LS_B:  result = {{24{lane_b[7]}}, lane_b};
      RV32I_FUNCT3_LS_BU: result = {24'h0, lane_b};
      RV32I_FUNCT3_LS_H:  result = {{16{lane_h[15]}}, lane_h};
      RV32I_FUNCT3_LS_HU: result = {16'h0, lane_h};
      RV32I_FUNCT3_LS_W:  result = data;
      default:            result = '0;
    endcase
    return result;
  endfunction

  function automatic logic gecko_load_misaligned(
    input logic [1:0] offset,
    input logic [2:0] op
  );
    logic half_op;
    half_op = (op == RV32I_FUNCT3_LS_H) || (op == RV32I_FUNCT3_LS_HU);
    return (half_op && offset[0]) || ((op == RV32I_FUNCT3_LS_W) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/gecko_load_pending_fifo.sv
// Small in-order queue of load commands awaiting their memory response.
module gecko_load_pending_fifo
  import gecko_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  gecko_mem_operation_t       push_data,
  input  logic                       pop,
  output gecko_mem_operation_t       head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  gecko_mem_operation_t entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      entries[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gecko_load_writeback.sv
// Memory-return stage: pairs queued load commands with in-order memory data and
// emits aligned, extended results. GECKO_LOAD_MISALIGN_CHECK_EN enables the misaligned-load fault.
module gecko_load_writeback
  import gecko_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  mem_command_valid,
  output logic                  mem_command_ready,
  input  logic [4:0]            mem_command_addr,
  input  logic [2:0]            mem_command_op,
  input  logic [1:0]            mem_command_offset,
  input  logic [2:0]            mem_command_reg_status,
  input  logic                  mem_command_jump_flag,

  input  logic                  mem_result_valid,
  output logic                  mem_result_ready,
  input  logic [DATA_WIDTH-1:0] mem_result_data,

  output logic                  load_result_valid,
  input  logic                  load_result_ready,
  output logic [31:0]           load_result_value,
  output logic [4:0]            load_result_addr,
  output logic                  load_result_speculative,
  output logic [2:0]            load_result_reg_status,
  output logic                  load_result_jump_flag,

  output logic                  load_fault
);

  gecko_mem_operation_t             cmd_in;
  gecko_mem_operation_t             head;
  logic [$clog2(DEPTH+1)-1:0]       pending_count;
  logic                             full;
  logic                             empty;
  logic                             fire;
  gecko_operation_t                 next_op;
  gecko_operation_t                 out_q;
  logic                             out_valid_q;

  assign cmd_in = '{
    addr:       mem_command_addr,
    op:         mem_command_op,
    offset:     mem_command_offset,
    reg_status: mem_command_reg_status,
    jump_flag:  mem_command_jump_flag
  };

  gecko_load_pending_fifo #(
    .DEPTH(DEPTH)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_command_valid && mem_command_ready),
    .push_data (cmd_in),
    .pop       (fire),
    .head      (head),
    .count     (pending_count),
    .full      (full),
    .empty     (empty)
  );

  assign mem_command_ready = !rst && !full;
  // A response is only taken when a command is waiting and the output slot frees this cycle.
  assign mem_result_ready  = !empty && (!out_valid_q || load_result_ready);
  assign fire              = mem_result_valid && mem_result_ready;

  always_comb begin
    next_op             = '0;
    next_op.value       = gecko_get_load_result(mem_result_data, head.offset, head.op);
    next_op.addr        = head.addr;
    next_op.speculative = 1'b0;
    next_op.reg_status  = head.reg_status;
    next_op.jump_flag   = head.jump_flag;
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
    if (gecko_load_misaligned(head.offset, head.op)) begin
      next_op.value = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_q       <= next_op;
    end else if (load_result_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign load_result_valid       = out_valid_q;
  assign load_result_value       = out_q.value;
  assign load_result_addr        = out_q.addr;
  assign load_result_speculative = out_q.speculative;
  assign load_result_reg_status  = out_q.reg_status;
  assign load_result_jump_flag   = out_q.jump_flag;

`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (fire && gecko_load_misaligned(head.offset, head.op)) begin
      fault_q <= 1'b1;
    end
  end

  assign load_fault = fault_q;
`else
  assign load_fault = 1'b0;
`endif

  // Upstream must never return data for a load that was not queued here.
  orphan_response_chk : assert property (
    @(posedge clk) disable iff (rst) !(mem_result_valid && (pending_count == '0))
  ) else $warning("gecko_load_writeback: memory response with no pending load command");

endmodule
